// File: rtl/axi4_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between a CPU-side master and the on-chip memory responder.
// Clock and reset stay as plain ports on the modules that use this bundle.
interface axi4_lite_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      s_AWVALID;
    logic                      s_AWREADY;
    logic [ADDR_WIDTH-1:0]     s_AWADDR;
    logic [2:0]                s_AWPROT;
    logic                      s_WVALID;
    logic                      s_WREADY;
    logic [DATA_WIDTH-1:0]     s_WDATA;
    logic [DATA_WIDTH/8-1:0]   s_WSTRB;
    logic                      s_BVALID;
    logic                      s_BREADY;
    logic [1:0]                s_BRESP;
    logic                      s_ARVALID;
    logic                      s_ARREADY;
    logic [ADDR_WIDTH-1:0]     s_ARADDR;
    logic [2:0]                s_ARPROT;
    logic                      s_RVALID;
    logic                      s_RREADY;
    logic [DATA_WIDTH-1:0]     s_RDATA;
    logic [1:0]                s_RRESP;

    modport master (
        output s_AWVALID, s_AWADDR, s_AWPROT,
        output s_WVALID, s_WDATA, s_WSTRB,
        output s_BREADY,
        output s_ARVALID, s_ARADDR, s_ARPROT,
        output s_RREADY,
        input  s_AWREADY, s_WREADY, s_BVALID, s_BRESP,
        input  s_ARREADY, s_RVALID, s_RDATA, s_RRESP
    );

    modport slave (
        input  s_AWVALID, s_AWADDR, s_AWPROT,
        input  s_WVALID, s_WDATA, s_WSTRB,
        input  s_BREADY,
        input  s_ARVALID, s_ARADDR, s_ARPROT,
        input  s_RREADY,
        output s_AWREADY, s_WREADY, s_BVALID, s_BRESP,
        output s_ARREADY, s_RVALID, s_RDATA, s_RRESP
    );
endinterface

// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite responder in front of a word-addressed on-chip memory with byte strobes.
// Independent read and write FSMs; out-of-range accesses answer SLVERR.
module axi4_lite_mem_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input logic                  iCLK,
    input logic                  iRST,
    axi4_lite_mem_slave_if.slave bus
);
    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_DATA,
        W_WAIT_ADDR,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_e;

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = (addr - BASE_ADDR) >> BYTE_SHIFT;
        return (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] addr_to_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = (addr - BASE_ADDR) >> BYTE_SHIFT;
        return IDX_W'(word);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  ready_en_q;
    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_W-1:0]     w_strb_q,  w_strb_d;
    logic [1:0]            bresp_q,   bresp_d;
    r_state_e              r_state_q, r_state_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;

    logic                  aw_ready, w_ready, ar_ready;
    logic                  aw_hs, w_hs, ar_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] commit_addr;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [STRB_W-1:0]     mem_strb;
    logic                  unused_prot;

    assign unused_prot = ^{bus.s_AWPROT, bus.s_ARPROT};

    assign aw_ready = ready_en_q & ((w_state_q == W_IDLE) | (w_state_q == W_WAIT_ADDR));
    assign w_ready  = ready_en_q & ((w_state_q == W_IDLE) | (w_state_q == W_WAIT_DATA));
    assign ar_ready = ready_en_q & (r_state_q == R_IDLE);

    assign aw_hs = bus.s_AWVALID & aw_ready;
    assign w_hs  = bus.s_WVALID  & w_ready;
    assign ar_hs = bus.s_ARVALID & ar_ready;

    assign bus.s_AWREADY = aw_ready;
    assign bus.s_WREADY  = w_ready;
    assign bus.s_BVALID  = (w_state_q == W_RESP);
    assign bus.s_BRESP   = bresp_q;
    assign bus.s_ARREADY = ar_ready;
    assign bus.s_RVALID  = (r_state_q == R_RESP);
    assign bus.s_RDATA   = rdata_q;
    assign bus.s_RRESP   = rresp_q;

    // Write channel: the commit is a single edge, whichever half arrives last.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        w_state_d   = w_state_q;
        aw_addr_d   = aw_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        bresp_d     = bresp_q;
        commit      = 1'b0;
        commit_addr = '0;
        mem_data    = '0;
        mem_strb    = '0;
        mem_we      = 1'b0;
        mem_idx     = '0;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit      = 1'b1;
                    commit_addr = bus.s_AWADDR;
                    mem_data    = bus.s_WDATA;
                    mem_strb    = bus.s_WSTRB;
                end else if (aw_hs) begin
                    aw_addr_d = bus.s_AWADDR;
                    w_state_d = W_WAIT_DATA;
                end else if (w_hs) begin
                    w_data_d  = bus.s_WDATA;
                    w_strb_d  = bus.s_WSTRB;
                    w_state_d = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                if (w_hs) begin
                    commit      = 1'b1;
                    commit_addr = aw_addr_q;
                    mem_data    = bus.s_WDATA;
                    mem_strb    = bus.s_WSTRB;
                end
            end
            W_WAIT_ADDR: begin
                if (aw_hs) begin
                    commit      = 1'b1;
                    commit_addr = bus.s_AWADDR;
                    mem_data    = w_data_q;
                    mem_strb    = w_strb_q;
                end
            end
            W_RESP: begin
                if (bus.s_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        if (commit) begin
            w_state_d = W_RESP;
            mem_we    = addr_in_range(commit_addr);
            mem_idx   = addr_to_index(commit_addr);
            bresp_d   = mem_we ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read data is captured from the array before any same-edge write lands.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_RESP;
                    if (addr_in_range(bus.s_ARADDR)) begin
                        rdata_d = mem[addr_to_index(bus.s_ARADDR)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_RESP: begin
                if (bus.s_RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
            ready_en_q <= 1'b0;
            w_state_q  <= W_IDLE;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= RESP_OKAY;
            r_state_q  <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            ready_en_q <= 1'b1;
            w_state_q  <= w_state_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bresp_q    <= bresp_d;
            r_state_q  <= r_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM; contents survive iRST.
    always_ff @(posedge iCLK) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (mem_strb[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_data[8*i +: 8];
                end
            end
        end
    end
endmodule
